// File: rtl/pstats_event_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pstats_event_gen_pkg
// Brief    : Command field layout, enums and LFSR helpers for pstats_event_gen
// Revision : 1.0 - initial release
// ============================================================================
package pstats_event_gen_pkg;

    localparam int c_port_lsb = 0;
    localparam int c_port_w   = 5;
    localparam int c_cnt_lsb  = 5;
    localparam int c_cnt_w    = 5;
    localparam int c_len_lsb  = 10;
    localparam int c_len_w    = 16;
    localparam int c_mode_lsb = 26;
    localparam int c_mode_w   = 2;
    localparam int c_trig_bit = 29;

    localparam logic [4:0]  c_bcast_port = 5'd31;
    localparam logic [15:0] c_lfsr_seed  = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5
    localparam logic [15:0] c_lfsr_taps  = 16'h002D;

    typedef enum logic [1:0] {
        MODE_CONT = 2'b00,
        MODE_GAP1 = 2'b01,
        MODE_RAND = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_GAP  = 2'b10
    } state_t;

    // Mode 2'b11 falls into the default and behaves like continuous
    function automatic logic [1:0] gap_len(input logic [1:0] mode, input logic [1:0] rnd);
        case (mode)
            MODE_GAP1: gap_len = 2'd1;
            MODE_RAND: gap_len = rnd;
            default:   gap_len = 2'd0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] lfsr);
        lfsr_next = {^(lfsr & c_lfsr_taps), lfsr[15:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pstats_event_gen_sync.sv
`default_nettype none
// ============================================================================
// Module   : pstats_event_gen_sync
// Brief    : Generic-width two-flop synchronizer, async active-low reset to 0
// Revision : 1.0 - initial release
// ============================================================================
module pstats_event_gen_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_data;
            r_sync <= r_meta;
        end
    end

    assign o_data = r_sync;

endmodule
`default_nettype wire

// File: rtl/pstats_event_gen.sv
`default_nettype none
// ============================================================================
// Module   : pstats_event_gen
// Brief    : Command-driven burst generator of per-port/per-counter event strobes
// Revision : 1.0 - initial release
// ============================================================================
module pstats_event_gen
    import pstats_event_gen_pkg::*;
#(
    parameter int G_NUM_PORTS = 18,
    parameter int G_CNT_PP    = 16,
    parameter int G_CMD_BITS  = 30
) (
    input  logic                            clk_sys_i,
    input  logic                            rst_n_i,
    input  logic [G_CMD_BITS-1:0]           cmd_i,
    output logic [G_NUM_PORTS*G_CNT_PP-1:0] events_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o,
    output logic                            dropped_o,
    output logic [31:0]                     sent_cnt_o
);

    localparam logic [5:0] c_num_ports = 6'(G_NUM_PORTS);
    localparam logic [5:0] c_cnt_pp    = 6'(G_CNT_PP);

    logic [G_CMD_BITS-1:0]           w_cmd_sync;
    logic                            w_unused_bits;
    logic                            w_trig;
    logic [c_port_w-1:0]             w_port;
    logic [c_cnt_w-1:0]              w_cnt_idx;
    logic [c_len_w-1:0]              w_len;
    logic [c_mode_w-1:0]             w_mode;
    logic                            w_cmd_ok;
    logic                            w_busy;
    logic [1:0]                      w_gap;
    logic [31:0]                     w_inc;
    logic [G_CNT_PP-1:0]             w_cnt_onehot;
    logic [G_NUM_PORTS*G_CNT_PP-1:0] w_mask;

    state_t                          r_state;
    logic [c_port_w-1:0]             r_port;
    logic [c_cnt_w-1:0]              r_cnt_idx;
    logic                            r_bcast;
    logic [c_mode_w-1:0]             r_mode;
    logic [c_len_w-1:0]              r_remaining;
    logic [1:0]                      r_gap_cnt;
    logic [15:0]                     r_lfsr;
    logic                            r_trig_prev;
    logic                            r_fin;
    logic                            r_acc_pend;
    logic                            r_rej_pend;
    logic [G_NUM_PORTS*G_CNT_PP-1:0] r_events;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_err;
    logic                            r_dropped;
    logic [31:0]                     r_sent;

    pstats_event_gen_sync #(
        .WIDTH (G_CMD_BITS)
    ) u_cmd_sync (
        .clk    (clk_sys_i),
        .rst_n  (rst_n_i),
        .i_data (cmd_i),
        .o_data (w_cmd_sync)
    );

    // Reserved and any upper command bits carry no function
    assign w_unused_bits = ^w_cmd_sync;

    assign w_trig    = w_cmd_sync[c_trig_bit] ^ r_trig_prev;
    assign w_port    = w_cmd_sync[c_port_lsb +: c_port_w];
    assign w_cnt_idx = w_cmd_sync[c_cnt_lsb +: c_cnt_w];
    assign w_len     = w_cmd_sync[c_len_lsb +: c_len_w];
    assign w_mode    = w_cmd_sync[c_mode_lsb +: c_mode_w];
    assign w_cmd_ok  = ((w_port == c_bcast_port) || ({1'b0, w_port} < c_num_ports))
                    && ({1'b0, w_cnt_idx} < c_cnt_pp);

    // busy_o still high in the cycle after the last strobe, so triggers there are dropped
    assign w_busy = (r_state != S_IDLE) || r_busy;
    assign w_gap  = gap_len(r_mode, r_lfsr[1:0]);
    assign w_inc  = r_bcast ? 32'(G_NUM_PORTS) : 32'd1;

    assign w_cnt_onehot = G_CNT_PP'(1) << r_cnt_idx;

    for (genvar p = 0; p < G_NUM_PORTS; p++) begin : g_port
        assign w_mask[p*G_CNT_PP +: G_CNT_PP] =
            (r_bcast || (r_port == 5'(p))) ? w_cnt_onehot : '0;
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_port      <= '0;
            r_cnt_idx   <= '0;
            r_bcast     <= 1'b0;
            r_mode      <= '0;
            r_remaining <= '0;
            r_gap_cnt   <= '0;
            r_lfsr      <= c_lfsr_seed;
            r_trig_prev <= 1'b0;
            r_fin       <= 1'b0;
            r_acc_pend  <= 1'b0;
            r_rej_pend  <= 1'b0;
            r_events    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_dropped   <= 1'b0;
            r_sent      <= '0;
        end else begin
            r_trig_prev <= w_cmd_sync[c_trig_bit];
            r_dropped   <= w_trig && w_busy;
            r_done      <= 1'b0;
            r_acc_pend  <= 1'b0;
            r_rej_pend  <= 1'b0;

            // Verdict is held one cycle so err_o moves together with the first strobe
            if (r_rej_pend) begin
                r_err <= 1'b1;
            end else if (r_acc_pend) begin
                r_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_events <= '0;
                    r_busy   <= 1'b0;
                    r_done   <= r_fin;
                    r_fin    <= 1'b0;
                    if (w_trig && !r_busy) begin
                        if (w_cmd_ok) begin
                            r_acc_pend  <= 1'b1;
                            r_port      <= w_port;
                            r_cnt_idx   <= w_cnt_idx;
                            r_bcast     <= (w_port == c_bcast_port);
                            r_mode      <= w_mode;
                            r_remaining <= w_len;
                            if (w_len == '0) begin
                                r_fin <= 1'b1;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end else begin
                            r_rej_pend <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    r_events    <= w_mask;
                    r_busy      <= 1'b1;
                    r_sent      <= r_sent + w_inc;
                    r_lfsr      <= lfsr_next(r_lfsr);
                    r_remaining <= r_remaining - c_len_w'(1);
                    if (r_remaining == c_len_w'(1)) begin
                        r_state <= S_IDLE;
                        r_fin   <= 1'b1;
                    end else if (w_gap != 2'd0) begin
                        r_state   <= S_GAP;
                        r_gap_cnt <= w_gap;
                    end
                end

                S_GAP: begin
                    r_events  <= '0;
                    r_gap_cnt <= r_gap_cnt - 2'd1;
                    if (r_gap_cnt == 2'd1) begin
                        r_state <= S_RUN;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign events_o   = r_events;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign dropped_o  = r_dropped;
    assign sent_cnt_o = r_sent;

endmodule
`default_nettype wire
